// File: rtl/rv_pkg.sv
// Shared RV64IM definitions used by the decoder and encoder:
// opcodes, funct3 groups, instruction formats and small helpers.
package rv_pkg;

   typedef enum logic [6:0] {
      OPC_LUI       = 7'b0110111,
      OPC_AUIPC     = 7'b0010111,
      OPC_JAL       = 7'b1101111,
      OPC_JALR      = 7'b1100111,
      OPC_BRANCH    = 7'b1100011,
      OPC_LOAD      = 7'b0000011,
      OPC_STORE     = 7'b0100011,
      OPC_OP_IMM    = 7'b0010011,
      OPC_OP_IMM_32 = 7'b0011011,
      OPC_OP        = 7'b0110011,
      OPC_OP_32     = 7'b0111011,
      OPC_MISC_MEM  = 7'b0001111,
      OPC_SYSTEM    = 7'b1110011
   } opcode_t;

   typedef enum logic [2:0] {
      F3_ADD = 3'b000, F3_SLL = 3'b001, F3_SLT = 3'b010, F3_SLTU = 3'b011,
      F3_XOR = 3'b100, F3_SRL = 3'b101, F3_OR  = 3'b110, F3_AND  = 3'b111
   } funct3_op_t;

   typedef enum logic [2:0] {
      BR_BEQ = 3'b000, BR_BNE = 3'b001, BR_BLT  = 3'b100,
      BR_BGE = 3'b101, BR_BLTU = 3'b110, BR_BGEU = 3'b111
   } funct3_branch_t;

   typedef enum logic [2:0] {
      LS_B  = 3'b000, LS_H  = 3'b001, LS_W  = 3'b010, LS_D = 3'b011,
      LS_BU = 3'b100, LS_HU = 3'b101, LS_WU = 3'b110
   } funct3_ls_t;

   typedef enum logic [2:0] {
      M_MUL = 3'b000, M_MULH = 3'b001, M_MULHSU = 3'b010, M_MULHU = 3'b011,
      M_DIV = 3'b100, M_DIVU = 3'b101, M_REM    = 3'b110, M_REMU  = 3'b111
   } funct3_mul_t;

   typedef enum logic [2:0] {
      SYS_PRIV  = 3'b000, SYS_CSRRW  = 3'b001, SYS_CSRRS  = 3'b010, SYS_CSRRC = 3'b011,
      SYS_CSRRWI = 3'b101, SYS_CSRRSI = 3'b110, SYS_CSRRCI = 3'b111
   } funct3_sys_t;

   typedef enum logic [2:0] {
      FMT_R, FMT_I, FMT_S, FMT_SB, FMT_U, FMT_UJ, FMT_BAD
   } format_t;

   function automatic format_t format_of(input logic [6:0] op);
      format_t fmt;
      case (op)
         OPC_OP, OPC_OP_32:                                        fmt = FMT_R;
         OPC_LOAD, OPC_JALR, OPC_OP_IMM, OPC_OP_IMM_32,
         OPC_MISC_MEM, OPC_SYSTEM:                                 fmt = FMT_I;
         OPC_STORE:                                                fmt = FMT_S;
         OPC_BRANCH:                                               fmt = FMT_SB;
         OPC_LUI, OPC_AUIPC:                                       fmt = FMT_U;
         OPC_JAL:                                                  fmt = FMT_UJ;
         default:                                                  fmt = FMT_BAD;
      endcase
      return fmt;
   endfunction

   // True when imm is a sign extension of its low 'bits' bits.
   function automatic logic fits_simm(input logic [63:0] imm, input int unsigned bits);
      logic [63:0] hi;
      hi = $signed(imm) >>> (bits - 1);
      return (hi == '0) || (hi == '1);
   endfunction

   function automatic logic is_shift_f3(input logic [2:0] f3);
      return (f3 == F3_SLL) || (f3 == F3_SRL);
   endfunction

endpackage

// File: rtl/rv_enc_fifo.sv
// Generic valid/ready FIFO of DEPTH entries (power of 2, >= 2); head is read
// combinationally so a write is visible the cycle after it is accepted.
module rv_enc_fifo #(
   parameter int DEPTH = 2,
   parameter int W     = 33
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         wr_valid,
   output logic         wr_ready,
   input  logic [W-1:0] wr_data,
   output logic         rd_valid,
   input  logic         rd_ready,
   output logic [W-1:0] rd_data
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr_reg;
   logic [AW-1:0] rd_ptr_reg;
   logic [AW:0]   count_reg;
   logic          push;
   logic          pop;

   assign wr_ready = !reset && (count_reg != FULL);
   assign rd_valid = (count_reg != '0);
   assign push     = wr_valid && wr_ready;
   assign pop      = rd_valid && rd_ready;
   assign rd_data  = rd_valid ? mem[rd_ptr_reg] : '0;

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr_reg] <= wr_data;
   end

   // Pointers are AW bits wide, so they wrap modulo DEPTH on their own.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
         if (pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
         case ({push, pop})
            2'b10:   count_reg <= count_reg + (AW+1)'(1);
            2'b01:   count_reg <= count_reg - (AW+1)'(1);
            default: count_reg <= count_reg;
         endcase
      end
   end

endmodule

// File: rtl/rv_inst_encoder.sv
// Packs decoded RV64IM fields into 32-bit instruction words behind an output FIFO.
// Define RV_ENC_RANGE_CHECK_EN to also flag immediates that do not fit their field.
module rv_inst_encoder
   import rv_pkg::*;
#(
   parameter int DEPTH     = 2,
   parameter int ERR_CNT_W = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [6:0]           in_op,
   input  logic [4:0]           in_rd,
   input  logic [4:0]           in_rs1,
   input  logic [4:0]           in_rs2,
   input  logic [2:0]           in_funct3,
   input  logic [6:0]           in_funct7,
   input  logic [63:0]          in_imm,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [31:0]          out_inst,
   output logic                 out_err,
   output logic [ERR_CNT_W-1:0] err_count
);
   format_t              fmt;
   logic                 shift_op;
   logic [31:0]          inst;
   logic                 err;
   logic                 accept;
   logic [32:0]          fifo_rd_data;
   logic [ERR_CNT_W-1:0] err_count_reg;

   always_comb begin
      fmt      = format_of(in_op);
      shift_op = (in_op == OPC_OP_IMM) && is_shift_f3(in_funct3);
      inst     = {25'b0, in_op};
      case (fmt)
         FMT_R:  inst = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_op};
         FMT_I: begin
            inst = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_op};
            // Word ops keep funct7 on top; the low five imm bits already sit in [24:20].
            if (in_op == OPC_OP_IMM_32) inst[31:25] = in_funct7;
            else if (shift_op)          inst[31:20] = {in_funct7[6:1], in_imm[5:0]};
         end
         FMT_S:  inst = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_op};
         FMT_SB: inst = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                         in_imm[4:1], in_imm[11], in_op};
         FMT_U:  inst = {in_imm[31:12], in_rd, in_op};
         FMT_UJ: inst = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, in_op};
         default: inst = {25'b0, in_op};
      endcase
   end

`ifdef RV_ENC_RANGE_CHECK_EN
   logic shift_op_32;
   assign shift_op_32 = (in_op == OPC_OP_IMM_32) && is_shift_f3(in_funct3);

   always_comb begin
      err = 1'b0;
      case (fmt)
         FMT_R: err = 1'b0;
         FMT_I, FMT_S: begin
            if (shift_op)         err = (in_imm[63:6] != '0);
            else if (shift_op_32) err = (in_imm[63:5] != '0);
            else                  err = !fits_simm(in_imm, 12);
         end
         FMT_SB:  err = !fits_simm(in_imm, 13) || in_imm[0];
         FMT_U:   err = (in_imm[11:0] != '0) || !fits_simm(in_imm, 32);
         FMT_UJ:  err = !fits_simm(in_imm, 21) || in_imm[0];
         default: err = 1'b1;
      endcase
   end
`else
   // Without range checking the upper immediate bits are simply dropped.
   logic imm_unused;
   assign imm_unused = ^in_imm[63:32];
   assign err        = (fmt == FMT_BAD);
`endif

   rv_enc_fifo #(
      .DEPTH (DEPTH),
      .W     (33)
   ) u_fifo (
      .clk      (clk),
      .reset    (reset),
      .wr_valid (in_valid),
      .wr_ready (in_ready),
      .wr_data  ({err, inst}),
      .rd_valid (out_valid),
      .rd_ready (out_ready),
      .rd_data  (fifo_rd_data)
   );

   assign out_err   = fifo_rd_data[32];
   assign out_inst  = fifo_rd_data[31:0];
   assign accept    = in_valid && in_ready;
   assign err_count = err_count_reg;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         err_count_reg <= '0;
      else if (accept && err && (err_count_reg != '1))
         err_count_reg <= err_count_reg + ERR_CNT_W'(1);
   end

endmodule

// File: doc/rv_inst_encoder.md
Name: rv_inst_encoder

Overview:
- Inverse of the instruction decoder: takes decoded RV64IM fields (op, rd, rs1, rs2, funct3, funct7, 64-bit immediate) and packs them into a 32-bit instruction word.
- Used by the self-checking front-end bench and the trace replayer to regenerate instruction words from decoded records.
- Valid/ready on both sides, with a 2-entry output FIFO that absorbs backpressure.
- Reports out-of-range or misaligned immediates per instruction and keeps a running error count.

Parameters:
- DEPTH, 2, output FIFO entries; must be a power of 2 and at least 2.
- ERR_CNT_W, 16, width of the saturating error counter.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  input record valid
- in_ready  out  1  encoder can accept a record
- in_op  in  7  opcode (LUI 0110111, AUIPC 0010111, JAL 1101111, JALR 1100111, BRANCH 1100011, LOAD 0000011, STORE 0100011, OP_IMM 0010011, OP_IMM_32 0011011, OP 0110011, OP_32 0111011, MISC_MEM 0001111, SYSTEM 1110011)
- in_rd, in_rs1, in_rs2  in  5 each  register fields
- in_funct3  in  3  funct3
- in_funct7  in  7  funct7
- in_imm  in  64  sign-extended immediate, byte offset for branches and jumps
- out_valid  out  1  out_inst valid
- out_ready  in  1  consumer accepts
- out_inst  out  32  encoded instruction
- out_err  out  1  immediate could not be represented; travels with out_inst
- err_count  out  ERR_CNT_W  count of accepted records with err=1, saturating

Behaviour:
- Accept: in_valid && in_ready. Pop: out_valid && out_ready.
- in_ready = (count != DEPTH). There is no same-cycle pass-through when the FIFO is full.
- Latency: a record accepted in cycle N gives out_valid=1 in cycle N+1 if the FIFO was empty. Encoding is combinational into the FIFO write port.
- Throughput: 1 record per cycle.
- Simultaneous push and pop: count is unchanged; allowed at every count, except that a push at count==DEPTH is impossible because in_ready=0.
- FIFO behaviour: pointers wrap modulo DEPTH; order is strictly FIFO. out_inst and out_err hold stable while out_valid && !out_ready.
- Field placement:
  - Always: inst[6:0]=op.
  - R-type (OP, OP_32): funct7 | rs2 | rs1 | funct3 | rd.
  - I-type (LOAD, JALR, OP_IMM, MISC_MEM, SYSTEM): imm[11:0] | rs1 | funct3 | rd.
  - OP_IMM shifts (funct3 001 or 101): inst[31:26]=funct7[6:1], inst[25:20]=imm[5:0].
  - OP_IMM_32 (any funct3): R-style funct7 in inst[31:25]. For shifts, inst[24:20]=imm[4:0]; otherwise the field is I-type.
  - S-type (STORE): imm[11:5] | rs2 | rs1 | funct3 | imm[4:0].
  - SB-type (BRANCH): imm[12] | imm[10:5] | rs2 | rs1 | funct3 | imm[4:1] | imm[11].
  - U-type (LUI, AUIPC): imm[31:12] | rd.
  - UJ-type (JAL): imm[20] | imm[10:1] | imm[11] | imm[19:12] | rd.
- Unknown opcode: out_inst={25'b0, op}, err=1.
- Reset values (asynchronous): count=0, pointers=0, out_valid=0, in_ready=0 while reset is asserted and 1 after release, out_inst=0, out_err=0, err_count=0. Reset mid-operation discards all FIFO contents. A record presented during reset is not accepted.
- err_count increments on accept when err=1 and sticks at all-ones.

Optional Feature:
- Macro: RV_ENC_RANGE_CHECK_EN.
- Defined, err is set on any of:
  - I and S types: in_imm not in [-2048, 2047].
  - SB: in_imm not in [-4096, 4094], or in_imm[0]=1.
  - UJ: in_imm not in [-2^20, 2^20-2], or in_imm[0]=1.
  - U: in_imm[11:0]!=0, or in_imm[63:31] not all equal.
  - OP_IMM shifts: imm[63:6]!=0. OP_IMM_32 shifts: imm[63:5]!=0.
  - Unknown opcode.
- Undefined: only unknown opcodes set err. Immediates are silently truncated to the field.

Decomposition:
- rv_pkg (shared with the decoder) holds: Opcode enum, Funct3_Op, Funct3_Branch, Funct3_LS, Funct3_Mul, Funct3_Sys, and a Format enum {FMT_R, FMT_I, FMT_S, FMT_SB, FMT_U, FMT_UJ, FMT_BAD}.
- Sub-module rv_enc_fifo: generic DEPTH x (32+1) valid/ready FIFO with count. The encoder top is combinational format select, pack, and range check, plus the error counter.

Test Plan:
- addi x1,x0,5 (op 0010011, rd 1, f3 0, imm 5) -> out_inst 0x00500093, out_err 0, one cycle after accept.
- sd x2,8(x1) (op 0100011, rs1 1, rs2 2, f3 3, imm 8) -> 0x0020B423. Then beq x0,x0,-4 (op 1100011, imm 0xFFFF_FFFF_FFFF_FFFC) -> 0xFE000EE3.
- lui x5 with imm 0x12345000 -> 0x123452B7. With RV_ENC_RANGE_CHECK_EN, addi imm 2048 -> out_err 1 and err_count 1; without the macro, out_err 0.
- out_ready=0 with 3 back-to-back records -> in_ready falls after 2 accepts and the 3rd is held. out_ready=1 -> outputs drain in order and in_ready rises in the cycle after the first pop.
- Simultaneous push and pop at count 1 for 10 cycles -> count stays 1 and the output order matches the input order.
- reset asserted mid-stream with 2 entries queued -> out_valid 0 immediately (asynchronous), err_count 0. After release, the first new record appears with the correct value.
